txuart: RTL and testbench
=========================

TXUART -- requirements
Module: txuart

Interface
REQ-001 SHALL provide parameter CLOCKS_PER_BAUD, default 1250 (12 MHz / 9600 baud), 24-bit unsigned, clock cycles per serial bit; legal range 2 to 2^24-1.
REQ-002 SHALL provide port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL provide port i_wr, input, 1 bit: byte write strobe.
REQ-005 SHALL provide port i_data, input, 8 bits: byte to transmit; sampled only on an accepted write.
REQ-006 SHALL provide port o_busy, output, 1 bit: high while a frame is in progress; writes ignored while high.
REQ-007 SHALL provide port o_uart_tx, output, 1 bit: serial line, idle high.

Function
REQ-008 SHALL accept a write on any rising edge where i_wr=1 and o_busy=0, and latch i_data into an internal shift register at that edge.
REQ-009 SHALL ignore i_wr while o_busy=1, with no effect on the frame in progress or the latched data.
REQ-010 SHALL drive, starting the cycle after acceptance: start bit (0), then i_data[0] through i_data[7] (LSB first), then optional parity (REQ-022), then stop bit (1).
REQ-011 SHALL hold each bit on o_uart_tx for exactly CLOCKS_PER_BAUD cycles, timed by a baud counter loaded with CLOCKS_PER_BAUD-1 at each bit start and decremented to 0.
REQ-012 SHALL implement states IDLE -> START -> DATA (3-bit index 0..7) -> [PARITY] -> STOP -> IDLE; each transition occurs when the baud counter is 0.
REQ-013 SHALL assert o_busy on the cycle after acceptance and hold it through the final cycle of the stop bit.
REQ-014 SHALL deassert o_busy on the first cycle after the stop bit completes, so that a frame is 10*CLOCKS_PER_BAUD cycles of busy (11* with parity).
REQ-015 SHALL, when i_wr is held high continuously, start the next start bit on the cycle after o_busy falls, giving back-to-back frames with one idle-high cycle between frames.
REQ-016 SHALL drive o_uart_tx from a register, with no combinational path from any input to o_uart_tx or o_busy.
REQ-017 SHALL keep o_uart_tx=1 in IDLE.

Reset
REQ-018 SHALL, on i_reset=1, immediately and asynchronously force o_uart_tx=1, o_busy=0, state IDLE, baud counter 0, and the shift register to 8'hFF.
REQ-019 SHALL abort a frame interrupted by reset mid-frame without completing it; the line returns high at once.
REQ-020 SHALL not accept a write on an edge where i_reset is high; the first acceptance is possible on the first rising edge after i_reset falls.

Configuration
REQ-021 SHALL use macro TXUART_PARITY_EN to control the parity feature.
REQ-022 SHALL, with TXUART_PARITY_EN defined, insert state PARITY between DATA bit 7 and STOP, driving even parity (XOR of the 8 data bits) for CLOCKS_PER_BAUD cycles, for an 11-bit frame.
REQ-023 SHALL, without TXUART_PARITY_EN, omit the PARITY state and its logic entirely, for a 10-bit frame.

Verification (CLOCKS_PER_BAUD=4 unless stated)
REQ-024 SHALL cover single byte: write 8'h55 at cycle 0 -> o_busy=1 from cycle 1; o_uart_tx reads 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit; o_busy=0 at cycle 41.
REQ-025 SHALL cover ignored write: write 8'hA5, then pulse i_wr with 8'h00 at cycle 10 -> transmitted data bits are exactly 1,0,1,0,0,1,0,1 and there is no second frame.
REQ-026 SHALL cover back-to-back: i_wr held high with 8'h0F then 8'hF0 -> two complete frames with exactly one idle-high cycle between the stop bit and the second start bit.
REQ-027 SHALL cover mid-frame reset: assert i_reset during DATA bit 3 of 8'h00 -> o_uart_tx=1 and o_busy=0 before the next clock edge; a write after release produces a full, correct frame.
REQ-028 SHALL cover parity, with TXUART_PARITY_EN: 8'h07 -> parity bit 1, frame length 44 cycles; 8'h03 -> parity bit 0.
REQ-029 SHALL cover the minimum divisor, CLOCKS_PER_BAUD=2, byte 8'hC3 -> every bit held exactly 2 cycles and o_busy high for 20 cycles.

Source files
------------

// File: rtl/txuart_if.sv
// txuart_if: byte-write handshake and serial line of the txuart transmitter.
// The bench or host drives i_wr/i_data through the master modport; the
// transmitter returns o_busy/o_uart_tx through the slave modport.
interface txuart_if;
  logic       i_wr;
  logic [7:0] i_data;
  logic       o_busy;
  logic       o_uart_tx;

  modport master (output i_wr, output i_data, input o_busy, input o_uart_tx);
  modport slave  (input i_wr, input i_data, output o_busy, output o_uart_tx);
endinterface

// File: rtl/txuart.sv
// txuart: 8N1 serial transmitter, LSB first, idle-high line.
// Each bit lasts CLOCKS_PER_BAUD clocks. Outputs o_busy and o_uart_tx come
// straight from registers. Define TXUART_PARITY_EN to add an even-parity bit
// between data bit 7 and the stop bit, which gives an 11-bit frame.
module txuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd1250
) (
  input  logic     i_clk,
  input  logic     i_reset,
  txuart_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef TXUART_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP  = 3'd4
  } state_t;

  localparam logic [23:0] BAUD_RELOAD = CLOCKS_PER_BAUD - 24'd1;

  state_t      state_q, state_d;
  logic [23:0] baud_q, baud_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sr_q, sr_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
`ifdef TXUART_PARITY_EN
  logic        par_q, par_d;
`endif

  // State register; reset aborts any frame and returns the line high at once
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      sr_q    <= '1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef TXUART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef TXUART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: the next line level is computed one cycle ahead, so
  // o_uart_tx changes on the same edge as the state it belongs to
  always_comb begin
    state_d = state_q;
    baud_d  = (baud_q != '0) ? baud_q - 24'd1 : baud_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
`ifdef TXUART_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.i_wr && !busy_q) begin
          state_d = START;
          baud_d  = BAUD_RELOAD;
          sr_d    = bus.i_data;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef TXUART_PARITY_EN
          par_d   = ^bus.i_data;
`endif
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          idx_d   = '0;
          baud_d  = BAUD_RELOAD;
          tx_d    = sr_q[0];
          sr_d    = {1'b1, sr_q[7:1]};
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (idx_q == 3'd7) begin
`ifdef TXUART_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = sr_q[0];
            sr_d  = {1'b1, sr_q[7:1]};
          end
        end
      end
`ifdef TXUART_PARITY_EN
      PARITY: begin
        if (baud_q == '0) begin
          state_d = STOP;
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_q == '0) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_uart_tx = tx_q;

endmodule

// File: tb/tb_txuart.sv
// tb_txuart: self-checking bench for txuart. The expected waveform is built
// as a list of frame bits, and each bit is repeated for its baud period.
module tb_txuart;
  localparam int CPB     = 4;
  localparam int CPB_MIN = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  txuart_if ifa ();
  txuart_if ifb ();

  txuart #(.CLOCKS_PER_BAUD(24'(CPB))) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifa.slave)
  );

  txuart #(.CLOCKS_PER_BAUD(24'(CPB_MIN))) dut_min (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifb.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic tx_of(input int sel);
    return (sel != 0) ? ifb.o_uart_tx : ifa.o_uart_tx;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? ifb.o_busy : ifa.o_busy;
  endfunction

  task automatic set_wr(input int sel, input logic wr, input logic [7:0] d);
    if (sel != 0) begin
      ifb.i_wr = wr; ifb.i_data = d;
    end else begin
      ifa.i_wr = wr; ifa.i_data = d;
    end
  endtask

  // Frame as the line should carry it: start, data LSB first, [parity], stop
  task automatic build_frame(input logic [7:0] data, output logic bits[$]);
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef TXUART_PARITY_EN
    bits.push_back(^data);
`endif
    bits.push_back(1'b1);
  endtask

  // Called at the negedge of the first cycle after acceptance. Returns at the
  // negedge of the first cycle after the frame, once the idle state is checked.
  // When pulse_at is greater than 0, i_wr is pulsed with 8'h00 at that cycle.
  task automatic check_frame(input int sel, input logic [7:0] data, input int cpb,
                             input string name, input int pulse_at);
    logic bits[$];
    int k;
    build_frame(data, bits);
    k = 1;
    foreach (bits[b]) begin
      for (int c = 0; c < cpb; c++) begin
        if (pulse_at > 0 && k == pulse_at) set_wr(sel, 1'b1, 8'h00);
        else if (pulse_at > 0 && k == pulse_at + 1) set_wr(sel, 1'b0, 8'h00);
        checks++;
        if (tx_of(sel) !== bits[b] || busy_of(sel) !== 1'b1) begin
          errors++;
          $display("FAIL %s cycle %0d bit %0d: tx=%b busy=%b, expected tx=%b busy=1",
                   name, k, b, tx_of(sel), busy_of(sel), bits[b]);
        end
        k++;
        @(negedge clk);
      end
    end
    checks++;
    if (tx_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s end cycle %0d: tx=%b busy=%b, expected tx=1 busy=0",
               name, k, tx_of(sel), busy_of(sel));
    end
  endtask

  task automatic write_byte(input int sel, input logic [7:0] d);
    @(negedge clk);
    set_wr(sel, 1'b1, d);
    @(negedge clk);
    set_wr(sel, 1'b0, 8'h00);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_wr(0, 1'b1, 8'h3C);
    set_wr(1, 1'b0, 8'h00);
    #1;
    checks++;
    if (ifa.o_uart_tx !== 1'b1 || ifa.o_busy !== 1'b0 ||
        ifb.o_uart_tx !== 1'b1 || ifb.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b/%b busy=%b/%b, expected tx=1 busy=0",
               ifa.o_uart_tx, ifb.o_uart_tx, ifa.o_busy, ifb.o_busy);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ifa.o_uart_tx !== 1'b1 || ifa.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL write_in_reset: tx=%b busy=%b, expected tx=1 busy=0",
               ifa.o_uart_tx, ifa.o_busy);
    end
    rst = 1'b0;
    @(negedge clk);
    set_wr(0, 1'b0, 8'h00);
    check_frame(0, 8'h3C, CPB, "reset_release", 0);
  endtask

  task automatic test_single;
    write_byte(0, 8'h55);
    check_frame(0, 8'h55, CPB, "single_55", 0);
  endtask

  task automatic test_ignored_write;
    write_byte(0, 8'hA5);
    check_frame(0, 8'hA5, CPB, "ignored_write", 10);
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      checks++;
      if (ifa.o_uart_tx !== 1'b1 || ifa.o_busy !== 1'b0) begin
        errors++;
        $display("FAIL no_second_frame cycle %0d: tx=%b busy=%b, expected tx=1 busy=0",
                 i, ifa.o_uart_tx, ifa.o_busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    set_wr(0, 1'b1, 8'h0F);
    @(negedge clk);
    set_wr(0, 1'b1, 8'hF0);
    check_frame(0, 8'h0F, CPB, "b2b_first", 0);
    @(negedge clk);
    set_wr(0, 1'b0, 8'h00);
    check_frame(0, 8'hF0, CPB, "b2b_second", 0);
  endtask

  task automatic test_random;
    logic [7:0] d;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      write_byte(0, d);
      check_frame(0, d, CPB, "random", 0);
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] d;
    write_byte(0, 8'h00);
    repeat (17) @(negedge clk);
    checks++;
    if (ifa.o_uart_tx !== 1'b0 || ifa.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bit3: tx=%b busy=%b, expected tx=0 busy=1",
               ifa.o_uart_tx, ifa.o_busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ifa.o_uart_tx !== 1'b1 || ifa.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tx=%b busy=%b, expected tx=1 busy=0",
               ifa.o_uart_tx, ifa.o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    d = 8'($urandom);
    write_byte(0, d);
    check_frame(0, d, CPB, "after_reset", 0);
  endtask

`ifdef TXUART_PARITY_EN
  task automatic test_parity;
    write_byte(0, 8'h07);
    check_frame(0, 8'h07, CPB, "parity_07", 0);
    write_byte(0, 8'h03);
    check_frame(0, 8'h03, CPB, "parity_03", 0);
  endtask
`endif

  task automatic test_min_divisor;
    write_byte(1, 8'hC3);
    check_frame(1, 8'hC3, CPB_MIN, "min_divisor", 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_ignored_write();
    test_back_to_back();
    test_random();
    test_mid_reset();
`ifdef TXUART_PARITY_EN
    test_parity();
`endif
    test_min_divisor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
